bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-low reset.
REQ-002 Instruction port: i_req in 1 request; i_addr in 16 word address; i_gnt out 1 grant pulse; i_rvalid out 1 read-data-valid pulse; i_rdata out 32 read data. The i port is read-only.
REQ-003 Data port: d_req in 1 request; d_we in 1 1=write 0=read; d_addr in 16 word address; d_wdata in 32 write data; d_gnt out 1 grant pulse; d_rvalid out 1 read-data-valid pulse; d_rdata out 32 read data.
REQ-004 Memory side: mem_rd_en out 1; mem_wr_en out 1; mem_addr out 16; mem_wdata out 32; mem_rdata in 32. The memory registers read data one clock after mem_rd_en, as on the team's 16384x32 BRAM.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE and WAIT, encoded in 2 bits.
REQ-006 IDLE: if any req is high at a rising edge, arbitrate per REQ-012. At that same edge, register the winner's addr, we (forced to 0 for i) and wdata, plus an owner bit, then go to ISSUE. With no req, stay in IDLE.
REQ-007 ISSUE, exactly 1 cycle: drive mem_addr and mem_wdata from the registers. Assert mem_wr_en for a write, otherwise mem_rd_en; never both. Assert the owner's gnt, registered, high this cycle only. Next state: IDLE for a write, WAIT for a read.
REQ-008 WAIT, exactly 1 cycle: at the exiting edge, latch mem_rdata into the owner's rdata register and set the owner's rvalid for the following cycle; next state is IDLE.
REQ-009 Latency: read = req sampled at edge E0, gnt in cycle E0..E1, rvalid and rdata valid in cycle E2..E3, i.e. 3 clocks; write occupancy = 2 clocks with no rvalid.
REQ-010 Requesters SHALL hold req and its payload until gnt is seen. Requesters SHALL drop req at the edge ending the gnt cycle. The block samples req only in IDLE; req held past that point is a new request.
REQ-011 rdata registers SHALL hold their last value until the next read completes for that port. rvalid is a 1-cycle pulse.
REQ-012 Simultaneous i_req and d_req in IDLE: the winner is selected per the Configuration section; the loser stays pending, with no gnt, and is served on its next IDLE sample.
REQ-013 mem_rd_en and mem_wr_en SHALL be 0 in IDLE and WAIT. mem_addr and mem_wdata hold their last registered value.
REQ-014 Back-to-back: the rvalid cycle of one read SHALL coincide with IDLE, so a new request is sampled in that same cycle without a bubble.
REQ-015 All 16 address bits SHALL pass through unmodified; address range checking is not performed here.

Reset
REQ-016 While rst=0, asynchronously: state=IDLE; i_gnt, d_gnt, i_rvalid, d_rvalid, mem_rd_en, mem_wr_en = 0; i_rdata, d_rdata, mem_addr, mem_wdata = 0; round-robin pointer = data-favoured.
REQ-017 Reset asserted during ISSUE or WAIT SHALL abort the transaction. No gnt or rvalid is produced for it after reset release. A write already on the memory interface at the reset edge is not guaranteed.
REQ-018 After rst rises, the first edge SHALL sample requests normally from IDLE.

Configuration
REQ-019 Macro BRAM_ARB_RR_EN.
- Defined: round-robin. A 1-bit pointer names the port that wins a tie and toggles to the other port after every grant. On reset it favours d.
- Undefined: fixed priority, d always wins ties; no pointer register exists.
REQ-020 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-021 Write then read: d write addr 16'h0010 data 32'hCAFE_F00D. Then d read 16'h0010. Required: d_gnt 1 cycle each; d_rvalid 3 clocks after the read is sampled; d_rdata = 32'hCAFE_F00D; i_rvalid never set.
REQ-022 i read addr 16'h0000 after reset. Required: i_rdata = 32'h0 with i_rvalid 3 clocks later; mem_wr_en stays 0 throughout.
REQ-023 i_req and d_req held together for 4 grants. Required with macro undefined: order d,d,d,d while d_req stays high. Required with BRAM_ARB_RR_EN: order d,i,d,i.
REQ-024 Back-to-back i reads of addrs 1, 2, 3 preloaded 32'h11, 32'h22, 32'h33. Required: rvalid every 3 clocks, data in order, no overlap of mem_rd_en with WAIT.
REQ-025 rst pulsed low during WAIT of a d read. Required: all outputs read 0 immediately; no d_rvalid after release; the next d read completes normally.
REQ-026 Check every cycle that mem_rd_en and mem_wr_en are never both 1 and that at most one gnt is high.

Source files
------------

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port (instruction read-only, data read/write) arbiter in
// front of a single-ported BRAM with one-cycle registered read data.
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT) -> IDLE.
// Build option: define BRAM_ARB_RR_EN for round-robin tie-breaking;
// default build uses fixed priority with the data port winning ties.
module bram_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;      // 1 = data port owns the transaction
    logic            we_q, we_d;
    logic            i_gnt_d, d_gnt_d;
    logic            i_rvalid_d, d_rvalid_d;
    logic [DW-1:0]   i_rdata_d, d_rdata_d;
    logic            mem_rd_en_d, mem_wr_en_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d;
    logic            sel_d_c;               // data port wins this IDLE sample

`ifdef BRAM_ARB_RR_EN
    logic            rr_d_q, rr_d_d;        // 1 = data port favoured on a tie
`endif

    // Tie-break between the two requesters
    always_comb begin
`ifdef BRAM_ARB_RR_EN
        sel_d_c = d_req & (~i_req | rr_d_q);
`else
        sel_d_c = d_req;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef BRAM_ARB_RR_EN
        rr_d_d      = rr_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    state_d     = ISSUE;
                    owner_d     = sel_d_c;
                    we_d        = sel_d_c & d_we;
                    mem_addr_d  = sel_d_c ? d_addr : i_addr;
                    mem_wdata_d = sel_d_c ? d_wdata : mem_wdata;
                    i_gnt_d     = ~sel_d_c;
                    d_gnt_d     = sel_d_c;
                    mem_wr_en_d = sel_d_c & d_we;
                    mem_rd_en_d = ~(sel_d_c & d_we);
`ifdef BRAM_ARB_RR_EN
                    rr_d_d      = ~sel_d_c;
`endif
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                state_d = IDLE;
                if (owner_q) begin
                    d_rdata_d  = mem_rdata;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = mem_rdata;
                    i_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef BRAM_ARB_RR_EN
            rr_d_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            i_gnt     <= i_gnt_d;
            d_gnt     <= d_gnt_d;
            i_rvalid  <= i_rvalid_d;
            d_rvalid  <= d_rvalid_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
            mem_rd_en <= mem_rd_en_d;
            mem_wr_en <= mem_wr_en_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
`ifdef BRAM_ARB_RR_EN
            rr_d_q    <= rr_d_d;
`endif
        end
    end

endmodule
